wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//  Two-master, one-slave-port Wishbone (classic, non-pipelined) arbiter.
//  Shares one interconnect port between the instruction-fetch master and the data master.
//  Fairness is round-robin.
//  A grant is locked for the whole bus cycle (while the owner holds CYC).
//  Sits between the two wb_master instances and wb_interconnect.
// PARAMETERS
//  AW              32   address width
//  DW              32   data width; select width is DW/8
//  TIMEOUT_CYCLES  255  stall limit in cycles (used only with WB_ARB_TIMEOUT_EN); must be >=2
// PORTS
//  i_clk      in   1      clock; all state changes on the rising edge
//  i_rst      in   1      asynchronous reset, active-high
//  i_m0_cyc   in   1      master 0 (fetch) bus cycle
//  i_m0_stb   in   1      master 0 strobe
//  i_m0_we    in   1      master 0 write enable
//  i_m0_adr   in   AW     master 0 address
//  i_m0_dat   in   DW     master 0 write data
//  i_m0_sel   in   DW/8   master 0 byte select
//  o_m0_ack   out  1      ack routed to master 0
//  o_m0_err   out  1      err routed to master 0
//  o_m0_dat   out  DW     read data to master 0
//  i_m1_*/o_m1_*          master 1 (data); same set and widths as master 0
//  o_s_cyc, o_s_stb, o_s_we  out  1        to slave port
//  o_s_adr    out  AW     to slave port
//  o_s_dat    out  DW     to slave port
//  o_s_sel    out  DW/8   to slave port
//  i_s_ack    in   1      from slave port
//  i_s_err    in   1      from slave port
//  i_s_dat    in   DW     from slave port
//  o_grant    out  2      one-hot current owner; 2'b00 when idle (debug/perf)
// BEHAVIOUR
//  - FSM states IDLE, OWN0, OWN1. Reset: state=IDLE, rr_last=1 (M0 wins the first tie).
//    All outputs are 0 during and after reset.
//  - IDLE: if any CYC is high, go to OWNx next edge.
//    Only one master requesting: it wins.
//    Both requesting: winner is ~rr_last.
//    Arbitration latency is 1 cycle from CYC to o_s_cyc.
//  - On entry to OWNx, rr_last<=x.
//  - OWNx: stay while i_mx_cyc=1, even across multiple acked beats.
//    When i_mx_cyc=0: other master's CYC=1 -> go to OWN(other) at the same edge (no idle bubble).
//    Otherwise -> IDLE.
//  - Slave outputs are combinational muxes of the owner's signals.
//    In IDLE, o_s_cyc=o_s_stb=o_s_we=0 and adr/dat/sel=0.
//    o_s_cyc=own & i_mx_cyc, so the slave sees CYC drop in the same cycle the master drops it.
//  - Return path: o_mx_ack=i_s_ack & ownx, o_mx_err=i_s_err & ownx.
//    o_mx_dat=i_s_dat when ownx, else 0.
//    The non-owner never sees ack or err.
//  - The non-owner waits; its request signals are ignored until it is granted (no buffering).
//  - A master dropping CYC in IDLE before a grant is not an error; no transaction is issued.
//  - Reset asserted mid-cycle: o_s_cyc deasserts asynchronously; the in-flight transfer is abandoned.
//  - ack and err together in one cycle: both are forwarded; the master decides priority.
// CONFIGURATION
//  - WB_ARB_TIMEOUT_EN defined: an 8..16-bit stall counter is cleared on grant and on every ack/err.
//    It increments each cycle o_s_stb=1 without ack/err.
//    When it reaches TIMEOUT_CYCLES: pulse o_mx_err=1 to the owner for one cycle, force o_s_cyc=0 that cycle,
//    then go to IDLE, or directly to the other owner if it is requesting.
//    A stalled slave therefore cannot lock out the other master.
//  - Not defined: no counter; err comes only from i_s_err; a stalled slave holds the bus indefinitely.
// TESTING
//  1 Reset then M0 CYC/STB read of 0x100; slave acks 2 cycles later with 0xDEADBEEF.
//    -> o_grant=01 one cycle after CYC; o_m0_dat=0xDEADBEEF with o_m0_ack; o_m1_ack stays 0.
//  2 M0 and M1 raise CYC on the same edge after reset.
//    -> M0 owns first; when M0 drops CYC, OWN1 at that edge; next tie goes to M0.
//  3 M1 holds CYC for 4 acked beats while M0 requests.
//    -> grant stays 01? no: stays 10 for all 4 beats; M0 granted only after M1 drops CYC.
//  4 M1 write adr 0x2000 dat 0x55 sel 4'b0001.
//    -> slave port sees exactly those values with o_s_we=1; o_s_* are all 0 when IDLE.
//  5 i_rst pulsed high while OWN0 with STB pending.
//    -> o_s_cyc=0 immediately; after release, state IDLE and first tie goes to M0.
//  6 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks an M0 read while M1 waits.
//    -> o_m0_err pulses at stall count 8; OWN1 on the following edge.
//    -> Without the macro, grant stays 01 for all 100 simulated cycles.

Source files
------------

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2 -- two-master, one-slave-port Wishbone classic arbiter.
//
// Shares one interconnect port between the instruction-fetch master (m0) and
// the data master (m1). Arbitration is round-robin; once granted, a master
// keeps the bus for its whole bus cycle (as long as it holds CYC). When the
// owner drops CYC and the other master is waiting, ownership moves at that
// same edge without an idle cycle.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   a stall counter aborts a bus cycle whose slave does not answer within
//   TIMEOUT_CYCLES strobed cycles. The owner gets a one-cycle err pulse and
//   the bus is released. Without the macro no counter exists and a stalled
//   slave holds the bus indefinitely.
//
// Parameters:
//   AW             address width
//   DW             data width (select width DW/8)
//   TIMEOUT_CYCLES stall limit, only used with WB_ARB_TIMEOUT_EN (>=2)
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_m0_* / o_m0_*              master 0 (fetch) request and return path
//   i_m1_* / o_m1_*              master 1 (data) request and return path
//   o_s_*                        request towards the slave port
//   i_s_ack, i_s_err, i_s_dat    response from the slave port
//   o_grant                      one-hot current owner, 2'b00 when idle
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_dat,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_dat,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  input  logic [DW-1:0]   i_s_dat,
  output logic [1:0]      o_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   rr_last;   // index of the master that owned the bus most recently
  logic   timeout;   // current bus cycle is being aborted this cycle
  logic   own0, own1;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0] stall_cnt;

  assign timeout = (state != IDLE) && (stall_cnt == CW'(TIMEOUT_CYCLES));

  // Cleared on every ownership change (including grant and release) and on
  // every slave answer; counts strobed cycles that got no answer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (state_nxt == IDLE || state_nxt != state) begin
      stall_cnt <= '0;
    end else if (i_s_ack || i_s_err) begin
      stall_cnt <= '0;
    end else if (o_s_stb) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;   // makes m0 the winner of the first tie
    end else begin
      state <= state_nxt;
      if (state_nxt == OWN0 && state != OWN0) rr_last <= 1'b0;
      else if (state_nxt == OWN1 && state != OWN1) rr_last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_nxt = rr_last ? OWN0 : OWN1;
        else if (i_m0_cyc)        state_nxt = OWN0;
        else if (i_m1_cyc)        state_nxt = OWN1;
      end
      // Handing over directly to a waiting master avoids an idle bubble.
      OWN0: if (!i_m0_cyc || timeout) state_nxt = i_m1_cyc ? OWN1 : IDLE;
      OWN1: if (!i_m1_cyc || timeout) state_nxt = i_m0_cyc ? OWN0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request path: owner's signals pass straight through so the slave sees
  // CYC fall in the same cycle the master drops it. An aborted cycle has its
  // CYC/STB forced low.
  always_comb begin
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    o_s_we  = 1'b0;
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    if (own0) begin
      o_s_cyc = i_m0_cyc & ~timeout;
      o_s_stb = i_m0_stb & ~timeout;
      o_s_we  = i_m0_we;
      o_s_adr = i_m0_adr;
      o_s_dat = i_m0_dat;
      o_s_sel = i_m0_sel;
    end else if (own1) begin
      o_s_cyc = i_m1_cyc & ~timeout;
      o_s_stb = i_m1_stb & ~timeout;
      o_s_we  = i_m1_we;
      o_s_adr = i_m1_adr;
      o_s_dat = i_m1_dat;
      o_s_sel = i_m1_sel;
    end
  end

  // Return path: only the owner ever sees ack/err/data.
  assign o_m0_ack = i_s_ack & own0;
  assign o_m0_err = (i_s_err | timeout) & own0;
  assign o_m0_dat = own0 ? i_s_dat : '0;
  assign o_m1_ack = i_s_ack & own1;
  assign o_m1_err = (i_s_err | timeout) & own1;
  assign o_m1_dat = own1 ? i_s_dat : '0;

  assign o_grant = {own1, own0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2 -- self-checking bench for wb_arbiter2.
// Directed scenarios compare against constants; the random scenario compares
// every output each cycle against a behavioural ownership model.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic        clk, rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_dat;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .o_m0_dat(m0_rdat),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_m1_dat(m1_rdat),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_dat(s_wdat), .o_s_sel(s_sel), .i_s_ack(s_ack), .i_s_err(s_err),
    .i_s_dat(s_dat), .o_grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Behavioural model: who owns the bus (0 none, 1 = m0, 2 = m1), who owned
  // it last, and how many unanswered strobed cycles the owner has seen.
  // -------------------------------------------------------------------------
  int   m_own, m_nxt, m_stall;
  logic m_last;          // 0: m0 owned last, 1: m1 owned last
  logic m_to, own_cyc, oth_cyc, own_stb;
  logic [140:0] exp_vec, got_vec;

  assign got_vec = {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel,
                    m0_ack, m0_err, m0_rdat, m1_ack, m1_err, m1_rdat, grant};

  always_comb begin
    m_to = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    m_to = (m_own != 0) && (m_stall == TO);
`endif
    own_cyc = 1'b0;
    oth_cyc = 1'b0;
    own_stb = 1'b0;
    if (m_own == 1) begin
      own_cyc = m0_cyc; oth_cyc = m1_cyc; own_stb = m0_stb;
    end else if (m_own == 2) begin
      own_cyc = m1_cyc; oth_cyc = m0_cyc; own_stb = m1_stb;
    end
    m_nxt = m_own;
    if (m_own == 0) begin
      if (m0_cyc && m1_cyc) m_nxt = m_last ? 1 : 2;
      else if (m0_cyc)      m_nxt = 1;
      else if (m1_cyc)      m_nxt = 2;
    end else if (!own_cyc || m_to) begin
      m_nxt = oth_cyc ? (3 - m_own) : 0;
    end
    exp_vec = '0;
    if (m_own == 1)
      exp_vec = {m0_cyc & ~m_to, m0_stb & ~m_to, m0_we, m0_adr, m0_dat, m0_sel,
                 s_ack, s_err | m_to, s_dat, 1'b0, 1'b0, 32'h0, 2'b01};
    else if (m_own == 2)
      exp_vec = {m1_cyc & ~m_to, m1_stb & ~m_to, m1_we, m1_adr, m1_dat, m1_sel,
                 1'b0, 1'b0, 32'h0, s_ack, s_err | m_to, s_dat, 2'b10};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own   <= 0;
      m_last  <= 1'b1;
      m_stall <= 0;
    end else begin
      m_own <= m_nxt;
      if (m_nxt != 0 && m_nxt != m_own) m_last <= (m_nxt == 2);
      if (m_nxt == 0 || m_nxt != m_own) m_stall <= 0;
      else if (s_ack || s_err)          m_stall <= 0;
      else if (own_stb)                 m_stall <= m_stall + 1;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // -------------------------------------------------------------------------
  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 0;
    s_ack = 0; s_err = 0; s_dat = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom; m1_cyc = 1; m1_stb = 1;
    m1_adr = $urandom; s_ack = 1; s_err = 1; s_dat = $urandom;
    #1;
    n_checks++;
    if (got_vec !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", got_vec);
    end
    @(negedge clk); #1;
    n_checks++;
    if (got_vec !== '0) begin
      n_fail++; $display("FAIL reset_held_outputs: got %h want 0", got_vec);
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_read();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100;
    #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL read_pregrant: grant %b want 00", grant);
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 32'h100) begin
      n_fail++; $display("FAIL read_grant: grant %b cyc %b adr %h want 01 1 00000100", grant, s_cyc, s_adr);
    end
    @(negedge clk);
    @(negedge clk);
    s_ack = 1; s_dat = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEADBEEF || m1_ack !== 1'b0 || m1_rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL read_ack: m0_ack %b m0_dat %h m1_ack %b m1_dat %h want 1 deadbeef 0 0", m0_ack, m0_rdat, m1_ack, m1_rdat);
    end
    @(negedge clk);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0 || grant !== 2'b01) begin
      n_fail++; $display("FAIL read_cyc_drop: cyc %b grant %b want 0 01", s_cyc, grant);
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL read_release: grant %b want 00", grant);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL tie_first: grant %b want 01", grant);
    end
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    #1;
    n_checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b0) begin
      n_fail++; $display("FAIL tie_drop: grant %b cyc %b want 01 0", grant, s_cyc);
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b10 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL tie_handover: grant %b cyc %b want 10 1", grant, s_cyc);
    end
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL tie_second: grant %b want 01", grant);
    end
  endtask

  task automatic test_burst();
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 8; i++) begin
      s_ack = i[0];
      s_dat = 32'h1000 + i;
      #1;
      n_checks++;
      if (grant !== 2'b10 || m0_ack !== 1'b0 || m1_ack !== i[0]) begin
        n_fail++; $display("FAIL burst_beat%0d: grant %b m0_ack %b m1_ack %b want 10 0 %b", i, grant, m0_ack, m1_ack, i[0]);
      end
      @(negedge clk);
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL burst_release: grant %b want 01", grant);
    end
  endtask

  task automatic test_write();
    do_reset();
    m1_we = 1; m1_adr = 32'h2000; m1_dat = 32'h55; m1_sel = 4'b0001;
    m0_we = 1; m0_adr = 32'hFFFF; m0_dat = 32'hAA; m0_sel = 4'b1111;
    #1;
    n_checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel} !== '0) begin
      n_fail++; $display("FAIL write_idle: cyc %b stb %b we %b adr %h dat %h sel %b want all 0", s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel);
    end
    m1_cyc = 1; m1_stb = 1;
    @(negedge clk); #1;
    n_checks++;
    if (s_cyc !== 1 || s_stb !== 1 || s_we !== 1 || s_adr !== 32'h2000 || s_wdat !== 32'h55 || s_sel !== 4'b0001) begin
      n_fail++; $display("FAIL write_port: cyc %b stb %b we %b adr %h dat %h sel %b want 1 1 1 2000 55 0001", s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    @(negedge clk); #1;
    n_checks++;
    if (s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_owned: cyc %b want 1", s_cyc);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_async: cyc %b grant %b want 0 00", s_cyc, grant);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_tie: grant %b want 01", grant);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k <= TO; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (k < TO && (grant !== 2'b01 || m0_err !== 1'b0 || s_cyc !== 1'b1)) begin
        n_fail++; $display("FAIL timeout_stall%0d: grant %b err %b cyc %b want 01 0 1", k, grant, m0_err, s_cyc);
      end else if (k == TO && (grant !== 2'b01 || m0_err !== 1'b1 || s_cyc !== 1'b0 || m1_err !== 1'b0)) begin
        n_fail++; $display("FAIL timeout_pulse: grant %b m0_err %b cyc %b m1_err %b want 01 1 0 0", grant, m0_err, s_cyc, m1_err);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b10 || m0_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_handover: grant %b m0_err %b want 10 0", grant, m0_err);
    end
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (grant !== 2'b01 || m0_err !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: grant %b err %b want 01 0", k, grant, m0_err);
      end
    end
`endif
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = 1'($urandom_range(1)); m1_stb = 1'($urandom_range(1));
      m0_we  = 1'($urandom_range(1)); m1_we  = 1'($urandom_range(1));
      m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom_range(15));
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom_range(15));
      s_ack  = 1'($urandom_range(1));
      s_err  = ($urandom_range(7) == 0);
      s_dat  = $urandom;
      #1;
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, got_vec, exp_vec);
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_read();
    test_tie();
    test_burst();
    test_write();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
